// File: rtl/csi2tx_pulse_hs_tx.sv
// Toggle-handshake event transmitter: queues clk_in pulses and issues
// them one at a time as req_tgl transitions, retiring on ack_tgl echo.
module csi2tx_pulse_hs_tx #(
  parameter int CNT_W = 4
) (
  input  logic             clk_in,
  input  logic             rsta,
  input  logic             in_pulse,
  input  logic             ack_tgl,
  output logic             req_tgl,
  output logic             busy,
  output logic             done_pulse,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             overflow,
  output logic             ack_err
);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  state_t           state_nx;
  logic             ack_s1;
  logic             ack_s2;
  logic             issue;
  logic             q_inc;
  logic             q_dec;
  logic             q_full;
  logic             q_empty;
  logic             req_nx;
  logic             done_nx;
  logic             ovf_nx;
  logic             err_nx;
  logic [CNT_W-1:0] pend_nx;

  always_ff @(posedge clk_in or posedge rsta) begin
    if (rsta) begin
      ack_s1 <= 1'b0;
      ack_s2 <= 1'b0;
    end else begin
      ack_s1 <= ack_tgl;
      ack_s2 <= ack_s1;
    end
  end

  assign q_empty = (pend_cnt == '0);
  assign q_full  = (pend_cnt == CNT_MAX);

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    done_nx  = 1'b0;
    err_nx   = ack_err;
    unique case (state)
      IDLE: begin
        if (ack_s2 != req_tgl) err_nx = 1'b1;
        if (!q_empty || in_pulse) begin
          issue    = 1'b1;
          state_nx = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_s2 == req_tgl) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
    endcase
  end

  // A pulse is queued unless it is the one being issued straight away.
  always_comb begin
    q_dec   = issue && !q_empty;
    q_inc   = in_pulse && !(issue && q_empty);
    ovf_nx  = q_inc && !q_dec && q_full;
    req_nx  = req_tgl ^ issue;
    pend_nx = pend_cnt;
    unique case (1'b1)
      (q_inc && !q_dec && !q_full): pend_nx = pend_cnt + CNT_ONE;
      (q_dec && !q_inc):            pend_nx = pend_cnt - CNT_ONE;
      default:                      pend_nx = pend_cnt;
    endcase
  end

  always_ff @(posedge clk_in or posedge rsta) begin
    if (rsta) begin
      state      <= IDLE;
      req_tgl    <= 1'b0;
      busy       <= 1'b0;
      done_pulse <= 1'b0;
      pend_cnt   <= '0;
      overflow   <= 1'b0;
      ack_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      req_tgl    <= req_nx;
      busy       <= (state_nx == WAIT_ACK);
      done_pulse <= done_nx;
      pend_cnt   <= pend_nx;
      overflow   <= ovf_nx;
      ack_err    <= err_nx;
    end
  end

endmodule
